// File: rtl/clk_pkg.sv
// ---------------------------------------------------------------------------
// clk_pkg
//   Shared definitions for the clock/timer display chain.
//   - DIGIT_W            : default width of one BCD display digit
//   - rpt_state_t        : state encoding of the button auto-repeat FSM
//   - DEF_HOLD_CYCLES    : hold time before auto-repeat starts (1 s at 100 Hz)
//   - DEF_REPEAT_CYCLES  : auto-repeat period (250 ms at 100 Hz)
// ---------------------------------------------------------------------------
package clk_pkg;

  localparam int DIGIT_W = 4;

  // Defaults chosen for a 100 Hz clk_out.
  localparam int DEF_HOLD_CYCLES   = 100;
  localparam int DEF_REPEAT_CYCLES = 25;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// ---------------------------------------------------------------------------
// btn_autorepeat
//   Converts a debounced button level into single-cycle step pulses:
//   one step on the press, one more after HOLD_CYCLES cycles of holding,
//   then one every REPEAT_CYCLES cycles until release.
//
// Ports
//   clk_out  in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   btn      in   debounced button level
//   step     out  combinational step pulse, valid in the cycle it is asserted
// ---------------------------------------------------------------------------
module btn_autorepeat
  import clk_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_out,
  input  logic rst,
  input  logic btn,
  output logic step
);

  localparam int CNT_N = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = cnt_width(CNT_N);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rpt_state_t       r_state;
  rpt_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_btn_prev;
  // r_armed stays low after reset until the button has been seen released,
  // so a button held straight through reset does not count as a new press.
  logic             r_armed;
  logic             w_press;

  assign w_press = btn & ~r_btn_prev & r_armed;

  always_ff @(posedge clk_out) begin
    if (rst) begin
      r_state    <= RPT_IDLE;
      r_cnt      <= CNT_ZERO;
      r_btn_prev <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_btn_prev <= btn;
      r_armed    <= r_armed | ~btn;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    step        = 1'b0;
    case (r_state)
      RPT_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (w_press) begin
          step        = 1'b1;
          w_state_nxt = RPT_HOLD;
        end
      end
      RPT_HOLD: begin
        if (!btn) begin
          w_state_nxt = RPT_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == HOLD_LAST) begin
          step        = 1'b1;
          w_state_nxt = RPT_REPEAT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      RPT_REPEAT: begin
        if (!btn) begin
          w_state_nxt = RPT_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == RPT_LAST) begin
          step      = 1'b1;
          w_cnt_nxt = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RPT_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/bcd_digit_counter_rpt.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter_rpt
//   One display digit: up/down counter over 0..eff_max with load, button
//   auto-repeat and cascadable carry/borrow strobes. Digits chain LSD->MSD
//   by feeding carry/borrow into the next digit's inc_in/dec_in.
//   eff_max = min(limit, MAX_DIGIT).
//
// Ports
//   clk_out     in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   en          in   step enable (load and rst act regardless)
//   inc_in      in   cascade increment, one step per high cycle
//   dec_in      in   cascade decrement, one step per high cycle
//   btn_up      in   debounced up button, auto-repeating
//   btn_dn      in   debounced down button, auto-repeating
//   limit       in   runtime maximum
//   load        in   synchronous load strobe
//   load_value  in   value to load (clamped to eff_max)
//   value       out  registered count
//   carry       out  combinational: up-step wraps eff_max->0 this cycle
//   borrow      out  combinational: down-step wraps 0->eff_max this cycle
//   at_max      out  registered value==eff_max, one cycle late
// ---------------------------------------------------------------------------
module bcd_digit_counter_rpt
  import clk_pkg::*;
#(
  parameter int WIDTH         = DIGIT_W,
  parameter int MAX_DIGIT     = 9,
  parameter int RESET_VAL     = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             en,
  input  logic             inc_in,
  input  logic             dec_in,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             borrow,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_DIGIT);
  localparam logic [WIDTH-1:0] RST_V      = WIDTH'((RESET_VAL > MAX_DIGIT) ? MAX_DIGIT : RESET_VAL);
  localparam logic             RST_AT_MAX = (RESET_VAL >= MAX_DIGIT);
  localparam logic [WIDTH-1:0] V_ZERO     = '0;
  localparam logic [WIDTH-1:0] V_ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_max(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] ceil);
    return (a > ceil) ? ceil : a;
  endfunction

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nxt;
  logic             r_at_max;
  logic [WIDTH-1:0] w_eff_max;
  logic             w_up_btn_step;
  logic             w_dn_btn_step;
  logic             w_up;
  logic             w_dn;
  logic             w_carry;
  logic             w_borrow;

  btn_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_rpt_up (
    .clk_out(clk_out),
    .rst    (rst),
    .btn    (btn_up),
    .step   (w_up_btn_step)
  );

  btn_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_rpt_dn (
    .clk_out(clk_out),
    .rst    (rst),
    .btn    (btn_dn),
    .step   (w_dn_btn_step)
  );

  assign w_eff_max = sat_max(limit, MAX_V);
  assign w_up      = inc_in | w_up_btn_step;
  assign w_dn      = dec_in | w_dn_btn_step;

  // Down has priority over up; a value left above a lowered limit is pulled
  // back to eff_max first and swallows any step in that cycle.
  always_comb begin
    w_value_nxt = r_value;
    w_carry     = 1'b0;
    w_borrow    = 1'b0;
    if (load) begin
      w_value_nxt = sat_max(load_value, w_eff_max);
    end else if (en) begin
      if (r_value > w_eff_max) begin
        w_value_nxt = w_eff_max;
      end else if (w_dn) begin
        if (r_value == V_ZERO) begin
          w_value_nxt = w_eff_max;
          w_borrow    = 1'b1;
        end else begin
          w_value_nxt = r_value - V_ONE;
        end
      end else if (w_up) begin
        if (r_value == w_eff_max) begin
          w_value_nxt = V_ZERO;
          w_carry     = 1'b1;
        end else begin
          w_value_nxt = r_value + V_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      r_value  <= RST_V;
      r_at_max <= RST_AT_MAX;
    end else begin
      r_value  <= w_value_nxt;
      r_at_max <= (r_value == w_eff_max);
    end
  end

  // Strobes feed the next digit combinationally; rst must mask them.
  assign carry  = w_carry & ~rst;
  assign borrow = w_borrow & ~rst;
  assign value  = r_value;
  assign at_max = r_at_max;

endmodule

// File: tb/tb_bcd_digit_counter_rpt.sv
module tb_bcd_digit_counter_rpt;

  localparam int W    = 4;
  localparam int MAXD = 9;
  localparam int RSTV = 0;
  localparam int HOLD = 100;
  localparam int REP  = 25;

  logic         clk_out = 1'b0;
  logic         rst, en, inc_in, dec_in, btn_up, btn_dn, load;
  logic [W-1:0] limit, load_value;
  logic [W-1:0] value;
  logic         carry, borrow, at_max;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_v   = 0;
  int m_am  = 0;
  int up_h  = -1;   // age (cycles) of the current up press, -1 = none
  int dn_h  = -1;
  bit up_blk = 1'b1; // press ignored until button seen low after reset
  bit dn_blk = 1'b1;
  logic obs_carry, obs_borrow;

  bcd_digit_counter_rpt #(
    .WIDTH(W), .MAX_DIGIT(MAXD), .RESET_VAL(RSTV),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk_out(clk_out), .rst(rst), .en(en), .inc_in(inc_in), .dec_in(dec_in),
    .btn_up(btn_up), .btn_dn(btn_dn), .limit(limit), .load(load),
    .load_value(load_value), .value(value), .carry(carry), .borrow(borrow),
    .at_max(at_max)
  );

  always #5 clk_out = ~clk_out;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // A held button steps at press age 0, HOLD, HOLD+REP, HOLD+2*REP, ...
  function automatic bit press_steps(input int age);
    if (age < 0) return 1'b0;
    if (age == 0) return 1'b1;
    return (age >= HOLD) && (((age - HOLD) % REP) == 0);
  endfunction

  // Called 1 time unit after a rising edge with inputs already applied;
  // consumes exactly one clock period.
  task automatic run_cycle(input string tag);
    int em, up_age, dn_age, nv, nam;
    bit up, dn, ec, eb;
    em     = (int'(limit) < MAXD) ? int'(limit) : MAXD;
    up_age = (btn_up && !up_blk) ? ((up_h < 0) ? 0 : up_h + 1) : -1;
    dn_age = (btn_dn && !dn_blk) ? ((dn_h < 0) ? 0 : dn_h + 1) : -1;
    up     = inc_in || press_steps(up_age);
    dn     = dec_in || press_steps(dn_age);
    nv = m_v; ec = 0; eb = 0;
    if (rst) nv = (RSTV > MAXD) ? MAXD : RSTV;
    else if (load) nv = (int'(load_value) < em) ? int'(load_value) : em;
    else if (en) begin
      if (m_v > em) nv = em;
      else if (dn) begin eb = (m_v == 0);  nv = (m_v + em) % (em + 1); end
      else if (up) begin ec = (m_v == em); nv = (m_v + 1) % (em + 1); end
    end
    nam = rst ? int'(RSTV >= MAXD) : int'(m_v == em);
    #4;
    obs_carry  = carry;
    obs_borrow = borrow;
    chk({tag, "_carry"},  32'(carry),  32'(ec));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    @(posedge clk_out);
    #1;
    m_v    = nv;
    m_am   = nam;
    up_h   = rst ? -1 : up_age;
    dn_h   = rst ? -1 : dn_age;
    up_blk = rst | (up_blk & btn_up);
    dn_blk = rst | (dn_blk & btn_dn);
    chk({tag, "_value"},  32'(value),  32'(m_v));
    chk({tag, "_at_max"}, 32'(at_max), 32'(m_am));
  endtask

  task automatic clear_in();
    rst = 0; load = 0; inc_in = 0; dec_in = 0;
  endtask

  initial begin
    rst = 1; en = 1; inc_in = 0; dec_in = 0; btn_up = 0; btn_dn = 0;
    load = 0; limit = 4'd15; load_value = 4'd0;
    @(posedge clk_out);
    #1;

    // 1: reset
    run_cycle("rst0");
    run_cycle("rst1");
    chk("t1_value", 32'(value), 32'd0);
    chk("t1_at_max", 32'(at_max), 32'd0);
    rst = 0;
    run_cycle("t1_idle");

    // 2: carry at 9 with limit 15
    load = 1; load_value = 4'd9; run_cycle("t2_load");
    load = 0; inc_in = 1; run_cycle("t2_inc");
    chk("t2_carry_hi", 32'(obs_carry), 32'd1);
    chk("t2_wrap", 32'(value), 32'd0);
    inc_in = 0;

    // 3: borrow with limit 2, then lowered limit pulls value down
    limit = 4'd2; load = 1; load_value = 4'd0; run_cycle("t3_load");
    load = 0; dec_in = 1; run_cycle("t3_dec");
    chk("t3_borrow_hi", 32'(obs_borrow), 32'd1);
    chk("t3_value2", 32'(value), 32'd2);
    dec_in = 0; limit = 4'd1; inc_in = 1; run_cycle("t3_clamp");
    chk("t3_clamp_val", 32'(value), 32'd1);
    chk("t3_no_strobe", 32'(obs_carry | obs_borrow), 32'd0);
    inc_in = 0;

    // en=0 discards steps
    limit = 4'd9; en = 0; inc_in = 1; run_cycle("en0");
    chk("en0_hold", 32'(value), 32'd1);
    en = 1; inc_in = 0;

    // 4: button held 200 cycles
    load = 1; load_value = 4'd0; run_cycle("t4_load");
    load = 0; btn_up = 1;
    repeat (200) run_cycle("t4_hold");
    btn_up = 0;
    chk("t4_final", 32'(value), 32'd5);
    repeat (30) run_cycle("t4_rel");
    chk("t4_after_rel", 32'(value), 32'd5);

    // 5: up+down together, load clamp
    load = 1; load_value = 4'd4; run_cycle("t5_load");
    load = 0; inc_in = 1; dec_in = 1; run_cycle("t5_both");
    chk("t5_dn_wins", 32'(value), 32'd3);
    inc_in = 0; dec_in = 0;
    load = 1; load_value = 4'd12; run_cycle("t5_ldclamp");
    chk("t5_clamped", 32'(value), 32'd9);
    chk("t5_no_carry", 32'(obs_carry), 32'd0);
    load = 0;

    // 6: reset mid-REPEAT, held button must be re-pressed
    load = 1; load_value = 4'd0; run_cycle("t6_load");
    load = 0; btn_up = 1;
    repeat (110) run_cycle("t6_hold");
    chk("t6_pre_rst", 32'(value), 32'd2);
    rst = 1; run_cycle("t6_rst");
    chk("t6_rst_val", 32'(value), 32'd0);
    rst = 0;
    repeat (30) run_cycle("t6_held");
    chk("t6_no_step", 32'(value), 32'd0);
    btn_up = 0; run_cycle("t6_rel");
    btn_up = 1; run_cycle("t6_press");
    chk("t6_repress", 32'(value), 32'd1);
    btn_up = 0; run_cycle("t6_rel2");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      load       = ($urandom_range(0, 19) == 0);
      en         = ($urandom_range(0, 7) != 0);
      inc_in     = ($urandom_range(0, 3) == 0);
      dec_in     = ($urandom_range(0, 3) == 0);
      load_value = W'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) limit = W'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 59) == 0) btn_dn = ~btn_dn;
      run_cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
